// File: rtl/alu_op_sequencer_pkg.sv
// Shared ALU opcode constants and sequencer state encoding.
package alu_seq_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOTA = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_ONES = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle between a control master and the sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = alu_seq_pkg::DEF_WIDTH
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_y, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_y, rsp_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives registered operands into a combinational ALU, waits SETTLE_CYCLES, captures the
// result into an accumulator and returns it on a valid/ready response; one command in flight.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       settle_cnt;
  logic             accept, capture, rsp_done;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_zero_q;

  assign bus.rsp_y    = rsp_y_q;
  assign bus.rsp_zero = rsp_zero_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    capture       = 1'b0;
    rsp_done      = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        busy          = 1'b1;
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU inputs only move on accept so alu_y is stable at capture and between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= OP_ZERO;
      settle_cnt <= '0;
      rsp_y_q    <= '0;
      rsp_zero_q <= 1'b0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        alu_a      <= bus.cmd_chain ? acc : bus.cmd_a;
        alu_b      <= bus.cmd_b;
        alu_sel    <= bus.cmd_op;
        settle_cnt <= SETTLE_LD;
      end else if (state == SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (capture) begin
        rsp_y_q    <= alu_y;
        rsp_zero_q <= (alu_y == '0);
        acc        <= alu_y;
      end
      if (rsp_done) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer against a transaction-level reference model.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 4;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y, acc;
  logic [2:0]       alu_sel;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]       m_acc;
  logic [CNT_W-1:0] m_count;
  logic [7:0]       sweep_exp [8];

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_sequencer #(
    .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .acc(acc), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ZERO: return 8'h00;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOTA: return ~a;
      OP_SUB:  return 8'((int'(a) - int'(b)) & 255);
      OP_ADD:  return 8'((int'(a) + int'(b)) % 256);
      default: return 8'hFF;
    endcase
  endfunction

  // Stand-in for the team's combinational 8-bit ALU.
  assign alu_y = ref_alu(alu_sel, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_chain = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    m_acc   = 8'h00;
    m_count = '0;
  endtask

  // Caller is at a negedge; returns at the negedge after the response handshake.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic chain, input int bp, input logic hold_nxt,
                         input logic [2:0] n_op, input logic [7:0] n_a, input logic [7:0] n_b);
    logic [7:0] exp_a, exp_y;
    int n, lat;
    exp_a = chain ? m_acc : a;
    exp_y = ref_alu(op, exp_a, b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_chain = chain;
    bus.rsp_ready = (bp == 0);
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    if (hold_nxt) begin
      bus.cmd_op    = n_op;
      bus.cmd_a     = n_a;
      bus.cmd_b     = n_b;
      bus.cmd_chain = 1'b0;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    check("alu_a", 32'(alu_a), 32'(exp_a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_sel", 32'(alu_sel), 32'(op));
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(SETTLE));
    check("rsp_y", 32'(bus.rsp_y), 32'(exp_y));
    check("rsp_zero", 32'(bus.rsp_zero), 32'(exp_y == 8'h00));
    check("acc", 32'(acc), 32'(exp_y));
    check("busy_resp", 32'(busy), 32'd1);
    check("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);
    m_acc = exp_y;
    repeat (bp) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_y", 32'(bus.rsp_y), 32'(exp_y));
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_alu_a_hold", 32'(alu_a), 32'(exp_a));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    m_count = m_count + 1'b1;
    @(negedge clk);
    check("op_count", 32'(op_count), 32'(m_count));
    check("rsp_valid_low", 32'(bus.rsp_valid), 32'd0);
    check("idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("alu_sel_hold", 32'(alu_sel), 32'(op));
  endtask

  task automatic run_random(input int count);
    for (int i = 0; i < count; i++) begin
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), 1'b0, 3'b000, 8'h00, 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    sweep_exp = '{8'h00, 8'h95, 8'hFF, 8'h6A, 8'h22, 8'h26, 8'h94, 8'hFF};

    do_reset();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
    check("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.rsp_ready = ~bus.rsp_ready;
      @(posedge clk);
      @(negedge clk);
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("idle_op_count", 32'(op_count), 32'd0);
    end

    // Reset lands while the command is still settling.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 8'h01;
    bus.cmd_b     = 8'h01;
    bus.cmd_chain = 1'b0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_acc", 32'(acc), 32'd0);
    check("midrst_alu_sel", 32'(alu_sel), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_cmd(3'(i), 8'hDD, 8'hB7, 1'b0, 0, 1'b0, 3'b000, 8'h00, 8'h00);
      check("sweep_lit", 32'(bus.rsp_y), 32'(sweep_exp[i]));
    end
    check("sweep_count", 32'(op_count), 32'd8);

    run_cmd(OP_ADD, 8'h10, 8'h05, 1'b0, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    check("chain1_lit", 32'(bus.rsp_y), 32'h15);
    run_cmd(OP_ADD, 8'hAA, 8'h03, 1'b1, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    check("chain2_lit", 32'(bus.rsp_y), 32'h18);
    run_cmd(OP_SUB, 8'h55, 8'h18, 1'b1, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    check("chain3_lit", 32'(bus.rsp_y), 32'h00);
    check("chain3_zero", 32'(bus.rsp_zero), 32'd1);
    check("chain3_acc", 32'(acc), 32'h00);

    run_cmd(OP_XOR, 8'($urandom), 8'($urandom), 1'b0, 5, 1'b1, OP_ADD, 8'h33, 8'h44);
    check("bp_held_not_taken", 32'(busy), 32'd0);
    run_cmd(OP_ADD, 8'h33, 8'h44, 1'b0, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    check("bp_next_lit", 32'(bus.rsp_y), 32'h77);

    run_random(20);

    do_reset();
    run_random(17);
    check("wrap_count", 32'(op_count), 32'd1);
    run_cmd(OP_ADD, 8'hFF, 8'h01, 1'b0, 0, 1'b0, 3'b000, 8'h00, 8'h00);
    check("wrap_add_y", 32'(bus.rsp_y), 32'h00);
    check("wrap_add_zero", 32'(bus.rsp_zero), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
